// File: rtl/dmem_arbiter_if.sv
// Bundle of core, port-1 and data-memory signals around dmem_arbiter.
// slave: the arbiter side; master: the requesters and memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  c_req_i;
    logic                  c_we_i;
    logic [ADDR_WIDTH-1:0] c_addr_i;
    logic [31:0]           c_wdata_i;
    logic [3:0]            c_be_i;
    logic                  stall_o;
    logic                  c_rvalid_o;
    logic [31:0]           c_rdata_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [31:0]           d_wdata_i;
    logic [3:0]            d_be_i;
    logic                  d_gnt_o;
    logic                  d_rvalid_o;
    logic [31:0]           d_rdata_o;

    logic                  m_en_o;
    logic                  m_we_o;
    logic [ADDR_WIDTH-1:0] m_addr_o;
    logic [31:0]           m_wdata_o;
    logic [3:0]            m_be_o;
    logic [31:0]           m_rdata_i;

    modport slave (
        input  c_req_i, c_we_i, c_addr_i, c_wdata_i, c_be_i,
        output stall_o, c_rvalid_o, c_rdata_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output m_en_o, m_we_o, m_addr_o, m_wdata_o, m_be_o,
        input  m_rdata_i
    );

    modport master (
        output c_req_i, c_we_i, c_addr_i, c_wdata_i, c_be_i,
        input  stall_o, c_rvalid_o, c_rdata_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  m_en_o, m_we_o, m_addr_o, m_wdata_o, m_be_o,
        output m_rdata_i
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core has fixed priority, port 1 gets a forced grant after starving.
// Optional DMEM_ARB_PERF_EN adds saturating stall/force performance counters.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]  perf_stall_o,
    output logic [31:0]  perf_force_o
`endif
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {CORE, FORCE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tag_vld_q, tag_vld_d;
    logic            tag_port_q, tag_port_d;
    logic            c_gnt, d_gnt, stall;
    logic            c_rv, d_rv;
    logic [ADDR_WIDTH-1:0] sel_addr;

    // FORCE only wins for port 1 while it still requests
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (state_q == FORCE && bus.d_req_i) d_gnt = 1'b1;
            else if (bus.c_req_i)                c_gnt = 1'b1;
            else if (bus.d_req_i)                d_gnt = 1'b1;
        end
    end

    always_comb begin
        cnt_d   = '0;
        state_d = CORE;
        if (bus.d_req_i && !d_gnt) cnt_d = cnt_q + 1'b1;
        if (state_q == CORE && bus.d_req_i && !d_gnt &&
            cnt_q == CW'(STARVE_LIMIT - 1))
            state_d = FORCE;
        tag_vld_d  = (c_gnt && !bus.c_we_i) || (d_gnt && !bus.d_we_i);
        tag_port_d = d_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CORE;
            cnt_q      <= '0;
            tag_vld_q  <= 1'b0;
            tag_port_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
        end
    end

    assign stall = bus.c_req_i && !c_gnt && !rst;

    assign sel_addr = c_gnt ? bus.c_addr_i :
                      d_gnt ? bus.d_addr_i : '0;

    assign bus.stall_o   = stall;
    assign bus.d_gnt_o   = d_gnt;
    assign bus.m_en_o    = c_gnt || d_gnt;
    assign bus.m_we_o    = c_gnt ? bus.c_we_i : (d_gnt && bus.d_we_i);
    assign bus.m_addr_o  = sel_addr & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    assign bus.m_wdata_o = c_gnt ? bus.c_wdata_i :
                           d_gnt ? bus.d_wdata_i : '0;
    assign bus.m_be_o    = c_gnt ? bus.c_be_i :
                           d_gnt ? bus.d_be_i : '0;

    assign c_rv = tag_vld_q && !tag_port_q && !rst;
    assign d_rv = tag_vld_q &&  tag_port_q && !rst;

    assign bus.c_rvalid_o = c_rv;
    assign bus.d_rvalid_o = d_rv;
    assign bus.c_rdata_o  = c_rv ? bus.m_rdata_i : '0;
    assign bus.d_rdata_o  = d_rv ? bus.m_rdata_i : '0;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] pstall_q, pforce_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pstall_q <= '0;
            pforce_q <= '0;
        end else begin
            if (stall && pstall_q != '1)
                pstall_q <= pstall_q + 32'd1;
            if (state_q == FORCE && d_gnt && pforce_q != '1)
                pforce_q <= pforce_q + 32'd1;
        end
    end

    assign perf_stall_o = pstall_q;
    assign perf_force_o = pforce_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, starvation sequences, random vs. model.
// A second instance with STARVE_LIMIT=1 checks the alternating boundary case.
module tb_dmem_arbiter;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(12)) bus ();
    dmem_arbiter_if #(.ADDR_WIDTH(12)) bus1 ();

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall, perf_force, perf_stall1, perf_force1;
`endif

    dmem_arbiter #(.ADDR_WIDTH(12), .STARVE_LIMIT(LIMIT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_stall_o (perf_stall),
        .perf_force_o (perf_force)
`endif
    );

    dmem_arbiter #(.ADDR_WIDTH(12), .STARVE_LIMIT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_stall_o (perf_stall1),
        .perf_force_o (perf_force1)
`endif
    );

    assign bus1.c_req_i   = bus.c_req_i;
    assign bus1.c_we_i    = bus.c_we_i;
    assign bus1.c_addr_i  = bus.c_addr_i;
    assign bus1.c_wdata_i = bus.c_wdata_i;
    assign bus1.c_be_i    = bus.c_be_i;
    assign bus1.d_req_i   = bus.d_req_i;
    assign bus1.d_we_i    = bus.d_we_i;
    assign bus1.d_addr_i  = bus.d_addr_i;
    assign bus1.d_wdata_i = bus.d_wdata_i;
    assign bus1.d_be_i    = bus.d_be_i;
    assign bus1.m_rdata_i = '0;

    // Environment memory: one-cycle read latency, byte-enabled writes
    logic [31:0] env_mem [0:1023];
    logic [31:0] mem_rdata = '0;
    assign bus.m_rdata_i = mem_rdata;

    always @(posedge clk) begin
        if (bus.m_en_o) begin
            if (bus.m_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.m_be_o[b])
                        env_mem[bus.m_addr_o[11:2]][8*b +: 8] <= bus.m_wdata_o[8*b +: 8];
            end else begin
                mem_rdata <= env_mem[bus.m_addr_o[11:2]];
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        c_req;
        logic        c_we;
        logic [11:0] c_addr;
        logic [31:0] c_wdata;
        logic [3:0]  c_be;
        logic        d_req;
        logic        d_we;
        logic [11:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic        e_stall;
        logic        e_dgnt;
        logic        e_men;
        logic        e_mwe;
        logic [11:0] e_maddr;
        logic        e_crv;
        logic [31:0] e_crd;
        logic        e_drv;
        logic [31:0] e_drd;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mkv(
        logic r, logic cq, logic cw, logic [11:0] ca, logic [31:0] cd,
        logic dq, logic dw, logic [11:0] da,
        logic st, logic dg, logic me, logic mw, logic [11:0] ma,
        logic crv, logic [31:0] crd, logic drv, logic [31:0] drd);
        vec_t v;
        v.rst = r;   v.c_req = cq; v.c_we = cw; v.c_addr = ca;
        v.c_wdata = cd; v.c_be = 4'hF;
        v.d_req = dq; v.d_we = dw; v.d_addr = da;
        v.d_wdata = 32'h0; v.d_be = 4'hF;
        v.e_stall = st; v.e_dgnt = dg; v.e_men = me; v.e_mwe = mw;
        v.e_maddr = ma; v.e_crv = crv; v.e_crd = crd;
        v.e_drv = drv; v.e_drd = drd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst           = v.rst;
        bus.c_req_i   = v.c_req;
        bus.c_we_i    = v.c_we;
        bus.c_addr_i  = v.c_addr;
        bus.c_wdata_i = v.c_wdata;
        bus.c_be_i    = v.c_be;
        bus.d_req_i   = v.d_req;
        bus.d_we_i    = v.d_we;
        bus.d_addr_i  = v.d_addr;
        bus.d_wdata_i = v.d_wdata;
        bus.d_be_i    = v.d_be;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        chk({nm, ".stall"}, 32'(bus.stall_o),    32'(v.e_stall));
        chk({nm, ".dgnt"},  32'(bus.d_gnt_o),    32'(v.e_dgnt));
        chk({nm, ".men"},   32'(bus.m_en_o),     32'(v.e_men));
        chk({nm, ".mwe"},   32'(bus.m_we_o),     32'(v.e_mwe));
        chk({nm, ".maddr"}, 32'(bus.m_addr_o),   32'(v.e_maddr));
        chk({nm, ".crv"},   32'(bus.c_rvalid_o), 32'(v.e_crv));
        chk({nm, ".crd"},   bus.c_rdata_o,       v.e_crd);
        chk({nm, ".drv"},   32'(bus.d_rvalid_o), 32'(v.e_drv));
        chk({nm, ".drd"},   bus.d_rdata_o,       v.e_drd);
    endtask

    // Reference model: port 1 wins when the core is idle or it has waited LIMIT cycles
    int          m_waits;
    bit          m_rv_v, m_rv_p, m_last_stall;
    logic [31:0] m_rv_d;
    logic [31:0] mdl [0:1023];

    task automatic model_step(inout vec_t v);
        bit dw, cw, we;
        logic [11:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        dw = v.d_req && (!v.c_req || m_waits >= LIMIT);
        cw = v.c_req && !dw;
        a  = cw ? v.c_addr : dw ? v.d_addr : 12'h0;
        we = cw ? v.c_we : (dw && v.d_we);
        wd = cw ? v.c_wdata : v.d_wdata;
        be = cw ? v.c_be : v.d_be;
        v.e_stall = v.c_req && !cw;
        v.e_dgnt  = dw;
        v.e_men   = cw || dw;
        v.e_mwe   = we;
        v.e_maddr = {a[11:2], 2'b00};
        v.e_crv   = m_rv_v && !m_rv_p;
        v.e_crd   = v.e_crv ? m_rv_d : 32'h0;
        v.e_drv   = m_rv_v && m_rv_p;
        v.e_drd   = v.e_drv ? m_rv_d : 32'h0;
        m_rv_v = 1'b0;
        if (cw || dw) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[a[11:2]][8*b +: 8] = wd[8*b +: 8];
            end else begin
                m_rv_v = 1'b1;
                m_rv_p = dw;
                m_rv_d = mdl[a[11:2]];
            end
        end
        m_waits = (v.d_req && !dw) ? m_waits + 1 : 0;
        m_last_stall = v.e_stall;
    endtask

    vec_t tbl [14];
    vec_t rv0;
    vec_t rv;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = 32'h1000_0000 + 32'(i);
            mdl[i]     = 32'h1000_0000 + 32'(i);
        end
        rv0 = mkv(1, 0, 0, 12'h0, 0, 0, 0, 12'h0, 0, 0, 0, 0, 12'h0, 0, 0, 0, 0);
        drive(rv0);

        //              rst cq cw caddr   cwdata        dq dw daddr   st dg me mw maddr   crv crd           drv drd
        tbl[0]  = mkv(1, 1, 0, 12'h010, 32'h0,        1, 0, 12'h020, 0, 0, 0, 0, 12'h000, 0, 32'h0,        0, 32'h0);
        tbl[1]  = mkv(0, 1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h000, 0, 0, 1, 1, 12'h010, 0, 32'h0,        0, 32'h0);
        tbl[2]  = mkv(0, 1, 0, 12'h010, 32'h0,        0, 0, 12'h000, 0, 0, 1, 0, 12'h010, 0, 32'h0,        0, 32'h0);
        tbl[3]  = mkv(0, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 0, 0, 0, 0, 12'h000, 1, 32'hDEADBEEF, 0, 32'h0);
        tbl[4]  = mkv(0, 0, 0, 12'h000, 32'h0,        1, 0, 12'h000, 0, 1, 1, 0, 12'h000, 0, 32'h0,        0, 32'h0);
        tbl[5]  = mkv(0, 0, 0, 12'h000, 32'h0,        1, 0, 12'h004, 0, 1, 1, 0, 12'h004, 0, 32'h0,        1, 32'h10000000);
        tbl[6]  = mkv(0, 0, 0, 12'h000, 32'h0,        1, 0, 12'h008, 0, 1, 1, 0, 12'h008, 0, 32'h0,        1, 32'h10000001);
        tbl[7]  = mkv(0, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 0, 0, 0, 0, 12'h000, 0, 32'h0,        1, 32'h10000002);
        tbl[8]  = mkv(0, 1, 0, 12'h010, 32'h0,        0, 0, 12'h000, 0, 0, 1, 0, 12'h010, 0, 32'h0,        0, 32'h0);
        tbl[9]  = mkv(1, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 0, 0, 0, 0, 12'h000, 0, 32'h0,        0, 32'h0);
        tbl[10] = mkv(0, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 0, 0, 0, 0, 12'h000, 0, 32'h0,        0, 32'h0);
        tbl[11] = mkv(0, 1, 1, 12'h017, 32'h12345678, 1, 0, 12'h017, 0, 0, 1, 1, 12'h014, 0, 32'h0,        0, 32'h0);
        tbl[12] = mkv(0, 0, 0, 12'h000, 32'h0,        1, 0, 12'h014, 0, 1, 1, 0, 12'h014, 0, 32'h0,        0, 32'h0);
        tbl[13] = mkv(0, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 0, 0, 0, 0, 12'h000, 0, 32'h0,        1, 32'h12345678);

        for (int i = 0; i < 14; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // Continuous core traffic: forced port-1 grant in cycle LIMIT+1
        run_vec(rv0, "rst2");
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            bus.c_req_i = 1'b1; bus.c_we_i = 1'b0; bus.c_addr_i = 12'h040;
            bus.d_req_i = (cyc <= 9); bus.d_we_i = 1'b0; bus.d_addr_i = 12'h020;
            @(negedge clk);
            chk($sformatf("starve.c%0d.dgnt", cyc),  32'(bus.d_gnt_o),    32'(cyc == 9));
            chk($sformatf("starve.c%0d.stall", cyc), 32'(bus.stall_o),    32'(cyc == 9));
            chk($sformatf("starve.c%0d.drv", cyc),   32'(bus.d_rvalid_o), 32'(cyc == 10));
            if (cyc == 10)
                chk("starve.drd", bus.d_rdata_o, 32'h10000008);
            if (cyc <= 9)
                chk($sformatf("lim1.c%0d.dgnt", cyc), 32'(bus1.d_gnt_o), 32'(cyc % 2 == 0));
        end
`ifdef DMEM_ARB_PERF_EN
        chk("perf.stall", perf_stall, 32'd1);
        chk("perf.force", perf_force, 32'd1);
`endif

        // Withdrawal clears the wait count: grant 8 cycles after reassertion
        run_vec(rv0, "rst3");
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            bus.c_req_i = 1'b1; bus.c_we_i = 1'b0; bus.c_addr_i = 12'h040;
            bus.d_req_i = (cyc != 6) && (cyc <= 15);
            bus.d_we_i = 1'b0; bus.d_addr_i = 12'h020;
            @(negedge clk);
            chk($sformatf("wdraw.c%0d.dgnt", cyc), 32'(bus.d_gnt_o), 32'(cyc == 15));
        end

        // Random traffic against the reference model
        run_vec(rv0, "rst4");
        m_waits = 0; m_rv_v = 1'b0; m_rv_p = 1'b0; m_rv_d = '0; m_last_stall = 1'b0;
        rv = rv0;
        rv.rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!m_last_stall) begin
                rv.c_req   = ($urandom_range(0, 9) < 7);
                rv.c_we    = 1'($urandom_range(0, 1));
                rv.c_addr  = 12'h100 + 12'($urandom_range(0, 15));
                rv.c_wdata = $urandom;
                rv.c_be    = 4'($urandom);
            end
            rv.d_req   = ($urandom_range(0, 9) < 6);
            rv.d_we    = 1'($urandom_range(0, 1));
            rv.d_addr  = 12'h100 + 12'($urandom_range(0, 15));
            rv.d_wdata = $urandom;
            rv.d_be    = 4'($urandom);
            model_step(rv);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
